// File: rtl/bp_coh_bridge_pkg.sv
// ----------------------------------------------------------------------------
// bp_coh_bridge_pkg
//   Types and constants that the coherence-link credit bridge shares with the
//   pod that instantiates it.
//   - coh_noc_flit_width_p     : coherence NoC flit width used by the pod
//   - bp_coh_credits_default_p : default credits per direction (and inbound
//                                FIFO depth)
//   - bp_coh_ready_and_link_s  : ready_and link bundle {v, data, ready_and_rev}
//
//   The bridge top can be built with BP_COH_LINK_BRIDGE_STATS_EN defined to
//   add traffic/stall counters; this package does not change with it.
// ----------------------------------------------------------------------------

// Link declaration macro with the same field order as the BaseJump STL
// declare_bsg_ready_and_link_sif_s, so the packed layout of the link matches.
`ifndef BP_COH_DECLARE_READY_AND_LINK_SIF_S
`define BP_COH_DECLARE_READY_AND_LINK_SIF_S(width_mp, name_mp) \
  typedef struct packed {                                      \
    logic                v;                                    \
    logic [width_mp-1:0] data;                                 \
    logic                ready_and_rev;                        \
  } name_mp
`endif

package bp_coh_bridge_pkg;

  localparam int coh_noc_flit_width_p     = 128;
  localparam int bp_coh_credits_default_p = 4;

  `BP_COH_DECLARE_READY_AND_LINK_SIF_S(coh_noc_flit_width_p, bp_coh_ready_and_link_s);

endpackage

// File: rtl/bp_coh_link_credit_fifo.sv
// ----------------------------------------------------------------------------
// bp_coh_link_credit_fifo
//   Inbound half of the credit bridge. It stores flits that arrive from the
//   far side and presents the oldest one to the tile as a ready_and source.
//   Every pop returns one credit to the far side, one cycle after the pop.
//
//   Ports
//     bp_clk_i, bp_reset_i : clock, asynchronous active-high reset
//     v_i, data_i          : inbound flit from the credit link (push)
//     ready_i              : tile-side ready_and (a pop happens when v_o & ready_i)
//     v_o, data_o          : FIFO head (data_o reads 0 while empty)
//     pop_o                : pop strobe for this cycle
//     credit_return_o      : registered single-cycle credit pulse, one per pop
// ----------------------------------------------------------------------------
module bp_coh_link_credit_fifo
  import bp_coh_bridge_pkg::*;
#(
  parameter int width_p = coh_noc_flit_width_p,
  parameter int els_p   = bp_coh_credits_default_p
) (
  input  logic               bp_clk_i,
  input  logic               bp_reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               ready_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               pop_o,
  output logic               credit_return_o
);

  localparam int cnt_width_lp = $clog2(els_p + 1);
  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] rd_ptr_q, rd_ptr_d;
  logic [ptr_width_lp-1:0] wr_ptr_q, wr_ptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic                    credit_return_q;
  logic                    empty, full, push, pop;

  // Occupancy is tracked separately from the pointers, so all els_p slots are
  // usable and full/empty never alias.
  assign empty = (count_q == '0);
  assign full  = (count_q == full_cnt_lp);
  assign pop   = ~empty & ready_i;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO
  // is accepted when it coincides with a pop.
  assign push  = v_i & (~full | pop);

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] ptr);
    return (ptr == last_ptr_lp) ? '0 : ptr + ptr_width_lp'(1);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    unique case ({push, pop})
      2'b10:   count_d = count_q + cnt_width_lp'(1);
      2'b01:   count_d = count_q - cnt_width_lp'(1);
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge value of every other flop, whatever the block order.
  always_ff @(posedge bp_clk_i or posedge bp_reset_i) begin
    if (bp_reset_i) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      credit_return_q <= 1'b0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      credit_return_q <= pop;
    end
  end

  // NOTE: the storage array has no reset; the count and pointers define which
  // entries are live, and leaving the array plain lets it map to RAM/latches.
  always_ff @(posedge bp_clk_i) begin
    if (push) mem_q[wr_ptr_q] <= data_i;
  end

  assign v_o             = ~empty;
  assign data_o          = empty ? '0 : mem_q[rd_ptr_q];
  assign pop_o           = pop;
  assign credit_return_o = credit_return_q;

  // The far side may only send with a credit in hand; a push into a full
  // FIFO with no pop means it has lost track of its credits.
  inbound_overflow_a: assert property (@(posedge bp_clk_i) disable iff (bp_reset_i)
    !(v_i && full && !pop));

endmodule

// File: rtl/bp_coh_link_credit_bridge.sv
// ----------------------------------------------------------------------------
// bp_coh_link_credit_bridge
//   Terminates one vertical end of a coherence NoC column. It turns the tile's
//   ready_and link into a registered valid/credit link that can cross a long
//   wire. The link is bidirectional.
//     outbound : link_i (ready_and) -> credit_v_o/credit_data_o, gated by a
//                credit counter that credit_return_i refills
//     inbound  : credit_v_i/credit_data_i -> FIFO -> link_o (ready_and),
//                and each pop returns a credit on credit_return_o
//
//   Ports
//     bp_clk_i, bp_reset_i : clock, asynchronous active-high reset
//     link_i               : {v, data, ready_and_rev} from the tile node
//     link_o               : {v, data, ready_and_rev} to the tile node
//     credit_v_o, credit_data_o : outbound flit, registered (latency 1)
//     credit_return_i      : one outbound credit returned by the far side
//     credit_v_i, credit_data_i : inbound flit
//     credit_return_o      : one inbound credit returned to the far side
//
//   Optional build macro BP_COH_LINK_BRIDGE_STATS_EN adds 32-bit wrapping
//   counters stat_out_flits_o, stat_in_flits_o and stat_stall_cycles_o.
// ----------------------------------------------------------------------------
module bp_coh_link_credit_bridge
  import bp_coh_bridge_pkg::*;
#(
  parameter int flit_width_p = coh_noc_flit_width_p,
  parameter int credits_p    = bp_coh_credits_default_p
) (
  input  logic                    bp_clk_i,
  input  logic                    bp_reset_i,
  input  logic [flit_width_p+1:0] link_i,
  output logic [flit_width_p+1:0] link_o,
  output logic                    credit_v_o,
  output logic [flit_width_p-1:0] credit_data_o,
  input  logic                    credit_return_i,
  input  logic                    credit_v_i,
  input  logic [flit_width_p-1:0] credit_data_i,
  output logic                    credit_return_o
`ifdef BP_COH_LINK_BRIDGE_STATS_EN
  ,
  output logic [31:0]             stat_out_flits_o,
  output logic [31:0]             stat_in_flits_o,
  output logic [31:0]             stat_stall_cycles_o
`endif
);

  localparam int credit_cnt_width_lp = $clog2(credits_p + 1);
  localparam logic [credit_cnt_width_lp-1:0] credits_full_lp = credit_cnt_width_lp'(credits_p);

  // Link field split: {v, data, ready_and_rev}.
  logic                    link_v_li, link_ready_li;
  logic [flit_width_p-1:0] link_data_li;
  assign link_v_li     = link_i[flit_width_p+1];
  assign link_data_li  = link_i[flit_width_p:1];
  assign link_ready_li = link_i[0];

  // ---------------- outbound: ready_and -> valid/credit ----------------
  logic [credit_cnt_width_lp-1:0] cnt_q, cnt_d;
  logic                           out_v_q;
  logic [flit_width_p-1:0]        out_data_q;
  logic                           ready_lo, accept;

  // Ready depends only on the counter (never on link_i.v), so the tile sees no
  // combinational loop. It is held low during reset, when the counter already
  // holds its full value.
  assign ready_lo = (cnt_q != '0) & ~bp_reset_i;
  assign accept   = link_v_li & ready_lo;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({accept, credit_return_i})
      2'b10:   cnt_d = cnt_q - credit_cnt_width_lp'(1);
      // A return into a full counter is a far-side protocol error; saturate.
      2'b01:   if (cnt_q != credits_full_lp) cnt_d = cnt_q + credit_cnt_width_lp'(1);
      default: ;
    endcase
  end

  always_ff @(posedge bp_clk_i or posedge bp_reset_i) begin
    if (bp_reset_i) begin
      cnt_q      <= credits_full_lp;
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      out_v_q <= accept;
      // Data holds its last value between flits, so only load on accept.
      if (accept) out_data_q <= link_data_li;
    end
  end

  assign credit_v_o    = out_v_q;
  assign credit_data_o = out_data_q;

  credit_overflow_a: assert property (@(posedge bp_clk_i) disable iff (bp_reset_i)
    !(credit_return_i && !accept && cnt_q == credits_full_lp));

  // ---------------- inbound: valid/credit -> ready_and ----------------
  logic                    fifo_v_lo;
  logic [flit_width_p-1:0] fifo_data_lo;
`ifdef BP_COH_LINK_BRIDGE_STATS_EN
  logic                    fifo_pop_lo;
`endif

  bp_coh_link_credit_fifo #(
    .width_p (flit_width_p),
    .els_p   (credits_p)
  ) inbound_fifo (
    .bp_clk_i        (bp_clk_i),
    .bp_reset_i      (bp_reset_i),
    .v_i             (credit_v_i),
    .data_i          (credit_data_i),
    .ready_i         (link_ready_li),
    .v_o             (fifo_v_lo),
    .data_o          (fifo_data_lo),
`ifdef BP_COH_LINK_BRIDGE_STATS_EN
    .pop_o           (fifo_pop_lo),
`else
    .pop_o           (),
`endif
    .credit_return_o (credit_return_o)
  );

  assign link_o = {fifo_v_lo, fifo_data_lo, ready_lo};

`ifdef BP_COH_LINK_BRIDGE_STATS_EN
  // ---------------- traffic / stall statistics ----------------
  logic [31:0] stat_out_q, stat_in_q, stat_stall_q;

  always_ff @(posedge bp_clk_i or posedge bp_reset_i) begin
    if (bp_reset_i) begin
      stat_out_q   <= '0;
      stat_in_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (accept)                       stat_out_q   <= stat_out_q + 32'd1;
      if (fifo_pop_lo)                  stat_in_q    <= stat_in_q + 32'd1;
      if (link_v_li && (cnt_q == '0))   stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_out_flits_o    = stat_out_q;
  assign stat_in_flits_o     = stat_in_q;
  assign stat_stall_cycles_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_bp_coh_link_credit_bridge.sv
// ----------------------------------------------------------------------------
// tb_bp_coh_link_credit_bridge
//   Self-checking bench for bp_coh_link_credit_bridge. A behavioural model
//   (credit integer, flit queue, pulse expectations) predicts every output.
//   Directed scenarios are followed by randomized, protocol-legal traffic.
//   Define BP_COH_LINK_BRIDGE_STATS_EN to also check the statistics ports.
// ----------------------------------------------------------------------------
module tb_bp_coh_link_credit_bridge;
  import bp_coh_bridge_pkg::*;

  localparam int W = 128;
  localparam int C = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         lv, lrdy, cret, cv;
  logic [W-1:0] ldata, cdata;
  logic [W+1:0] link_i, link_o;
  logic         credit_v_o, credit_return_o;
  logic [W-1:0] credit_data_o;
`ifdef BP_COH_LINK_BRIDGE_STATS_EN
  logic [31:0]  stat_out_flits_o, stat_in_flits_o, stat_stall_cycles_o;
`endif

  always #5 clk = ~clk;

  assign link_i = {lv, ldata, lrdy};

  bp_coh_link_credit_bridge #(
    .flit_width_p (W),
    .credits_p    (C)
  ) dut (
    .bp_clk_i        (clk),
    .bp_reset_i      (rst),
    .link_i          (link_i),
    .link_o          (link_o),
    .credit_v_o      (credit_v_o),
    .credit_data_o   (credit_data_o),
    .credit_return_i (cret),
    .credit_v_i      (cv),
    .credit_data_i   (cdata),
    .credit_return_o (credit_return_o)
`ifdef BP_COH_LINK_BRIDGE_STATS_EN
    ,
    .stat_out_flits_o    (stat_out_flits_o),
    .stat_in_flits_o     (stat_in_flits_o),
    .stat_stall_cycles_o (stat_stall_cycles_o)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int           m_cnt;        // credits the bridge currently holds
  logic [W-1:0] m_q[$];       // flits waiting for the tile, oldest first
  logic [W-1:0] m_last;       // last flit sent on the credit link
  int           m_out_n, m_in_n, m_stall_n;
  int           seen_v, seen_ret;

  function automatic void model_reset();
    m_cnt = C;
    m_q.delete();
    m_last = '0;
    m_out_n = 0;
    m_in_n = 0;
    m_stall_n = 0;
  endfunction

  // One clock cycle: drive inputs just after an edge, check the combinational
  // outputs mid-cycle, then check the registered outputs just after the edge.
  task automatic step(input logic ilv, input logic [W-1:0] ild, input logic ilrdy,
                      input logic icret, input logic icv, input logic [W-1:0] icd);
    bit acc, pop;
    lv = ilv; ldata = ild; lrdy = ilrdy; cret = icret; cv = icv; cdata = icd;
    #2;
    check("ready_and_rev", link_o[0], (m_cnt > 0));
    check("link_v", link_o[W+1], (m_q.size() > 0));
    if (m_q.size() > 0) check("link_data", link_o[W:1], m_q[0]);
    acc = ilv && (m_cnt > 0);
    pop = (m_q.size() > 0) && ilrdy;
    if (ilv && m_cnt == 0) m_stall_n++;
    if (acc) begin m_last = ild; m_out_n++; end
    if (pop) begin void'(m_q.pop_front()); m_in_n++; end
    if (icv) m_q.push_back(icd);
    m_cnt = m_cnt - int'(acc) + int'(icret);
    @(posedge clk);
    #1;
    check("credit_v", credit_v_o, acc);
    check("credit_data", credit_data_o, m_last);
    check("credit_return", credit_return_o, pop);
    seen_v   += int'(credit_v_o);
    seen_ret += int'(credit_return_o);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_credit_v"}, credit_v_o, 1'b0);
    check({tag, "_credit_data"}, credit_data_o, '0);
    check({tag, "_credit_return"}, credit_return_o, 1'b0);
    check({tag, "_link_v"}, link_o[W+1], 1'b0);
    check({tag, "_link_ready"}, link_o[0], 1'b0);
  endtask

  function automatic logic [W-1:0] rand_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst = 1'b1;
    lv = 0; ldata = '0; lrdy = 0; cret = 0; cv = 0; cdata = '0;
    model_reset();
    #1;
    check_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Burst with no credit returns: 4 flits leave, then the link stalls.
    seen_v = 0;
    for (int i = 0; i < 6; i++) step(1'b1, W'(i + 1), 1'b0, 1'b0, 1'b0, '0);
    check("burst_flit_count", seen_v, 4);
`ifdef BP_COH_LINK_BRIDGE_STATS_EN
    check("stat_stall_after_burst", stat_stall_cycles_o, 2);
`endif

    // cnt=0: a single return lets exactly one more flit through.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b1, W'('h77), 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, W'('h78), 1'b0, 1'b0, 1'b0, '0);

    // Raise cnt to 2, then accept and return together for 10 cycles.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    seen_v = 0;
    for (int i = 0; i < 10; i++) step(1'b1, W'(i + 1), 1'b0, 1'b1, 1'b0, '0);
    check("steady_flit_count", seen_v, 10);
    check("steady_last_data", credit_data_o, W'('hA));

    // Restore full credits.
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Inbound: fill with the tile stalled, then drain at full rate.
    seen_ret = 0;
    for (int i = 0; i < C; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, W'('hA0 + i));
    check("fill_no_credit_return", seen_ret, 0);
    for (int i = 0; i < C; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    check("drain_credit_pulses", seen_ret, C);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);

    // Full FIFO with simultaneous push and pop keeps 4 entries in order.
    for (int i = 0; i < C; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, W'('hB0 + i));
    step(1'b0, '0, 1'b1, 1'b0, 1'b1, W'('hB4));
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < C; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-burst: cnt=1, FIFO holding 3.
    for (int i = 0; i < 3; i++) step(1'b1, W'('hC0 + i), 1'b0, 1'b0, 1'b1, W'('hD0 + i));
    lv = 0; lrdy = 0; cret = 0; cv = 0;
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    // Full credit count again: four accepts, then a stall.
    for (int i = 0; i < C + 1; i++) step(1'b1, W'('hE0 + i), 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < C; i++) step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);

    // Randomized protocol-legal traffic in both directions.
    for (int n = 0; n < 400; n++) begin
      logic r_lv, r_lrdy, r_cret, r_cv, r_acc, r_pop;
      r_lv   = ($urandom_range(0, 3) != 0);
      r_lrdy = ($urandom_range(0, 2) != 0);
      r_acc  = r_lv && (m_cnt > 0);
      r_pop  = (m_q.size() > 0) && r_lrdy;
      r_cret = ((m_cnt < C) || r_acc) ? 1'($urandom_range(0, 1)) : 1'b0;
      r_cv   = ((m_q.size() < C) || r_pop) ? 1'($urandom_range(0, 1)) : 1'b0;
      step(r_lv, rand_flit(), r_lrdy, r_cret, r_cv, rand_flit());
    end

`ifdef BP_COH_LINK_BRIDGE_STATS_EN
    check("stat_out_flits", stat_out_flits_o, m_out_n);
    check("stat_in_flits", stat_in_flits_o, m_in_n);
    check("stat_stall_cycles", stat_stall_cycles_o, m_stall_n);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
